fib_index_finder: RTL and testbench

- Inverse of the Fibonacci incrementer: takes a value and returns the largest index n with F(n) <= value, plus the remainder value - F(n) and an exact-match flag.
- Sequence convention: F(0)=1, F(1)=1, F(2)=2, F(3)=3, F(4)=5, F(5)=8, F(6)=13, F(7)=21, F(k)=F(k-1)+F(k-2).
- Iterative, one Fibonacci step per clock, start/done handshake.
- Sits beside the incrementer/stack datapath so the controller can map results back to indices.

---
 rtl/fib_index_finder.sv | 178 +++++++++++++++++
 tb/tb_fib_index_finder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_index_finder.sv
// Iterative search for the largest n with F(n) <= value, using F(0)=F(1)=1.
// Define FIB_ZECK_EN to add the DECOMP state and the Zeckendorf bitmap port zeck.
module fib_index_finder #(
    parameter int WIDTH  = 5,
`ifdef FIB_ZECK_EN
    parameter int ZECK_W = 8,
`endif
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] rem,
    output logic             exact,
    output logic             zero_err
`ifdef FIB_ZECK_EN
    ,
    output logic [ZECK_W-1:0] zeck
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_DECOMP = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] v_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDX_W-1:0] n_r;
    logic [WIDTH:0]   sum_s;
    logic             grow_s;
    logic [WIDTH-1:0] diff_s;

    // Next Fibonacci term and its fit test; the extra sum bit keeps F(n-1)+F(n) from wrapping.
    always_comb begin
        sum_s  = {1'b0, a_r} + {1'b0, b_r};
        grow_s = (sum_s <= {1'b0, v_r});
        diff_s = v_r - b_r;
    end

`ifdef FIB_ZECK_EN
    logic [IDX_W-1:0] k_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] res_r;
    logic             take_s;
    logic [WIDTH-1:0] res_next_s;
    logic [IDX_W-1:0] k_next_s;
    logic             decomp_end_s;

    // Greedy Zeckendorf step: try F(k-1) against the residue, then slide the pair down one index.
    always_comb begin
        take_s       = (p_r <= res_r);
        res_next_s   = take_s ? (res_r - p_r) : res_r;
        k_next_s     = k_r - IDX_W'(1);
        decomp_end_s = (res_next_s == {WIDTH{1'b0}}) || (k_next_s == IDX_W'(1));
    end
`endif

    // Control FSM; handshake and result outputs are all registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            v_r      <= {WIDTH{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            n_r      <= {IDX_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            idx      <= {IDX_W{1'b0}};
            rem      <= {WIDTH{1'b0}};
            exact    <= 1'b0;
            zero_err <= 1'b0;
`ifdef FIB_ZECK_EN
            zeck     <= {ZECK_W{1'b0}};
            k_r      <= {IDX_W{1'b0}};
            p_r      <= {WIDTH{1'b0}};
            q_r      <= {WIDTH{1'b0}};
            res_r    <= {WIDTH{1'b0}};
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        v_r     <= value;
                        a_r     <= WIDTH'(1);
                        b_r     <= WIDTH'(1);
                        n_r     <= IDX_W'(1);
                        busy    <= 1'b1;
                        state_r <= S_STEP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (v_r == {WIDTH{1'b0}}) begin
                        idx      <= {IDX_W{1'b0}};
                        rem      <= {WIDTH{1'b0}};
                        exact    <= 1'b0;
                        zero_err <= 1'b1;
`ifdef FIB_ZECK_EN
                        zeck     <= {ZECK_W{1'b0}};
`endif
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= S_DONE;
                    end else if (grow_s) begin
                        a_r <= b_r;
                        b_r <= sum_s[WIDTH-1:0];
                        n_r <= n_r + IDX_W'(1);
                    end else begin
                        idx      <= n_r;
                        rem      <= diff_s;
                        exact    <= (diff_s == {WIDTH{1'b0}});
                        zero_err <= 1'b0;
`ifdef FIB_ZECK_EN
                        zeck     <= ZECK_W'(1'b1) << n_r;
                        res_r    <= diff_s;
                        k_r      <= n_r;
                        p_r      <= a_r;
                        q_r      <= b_r;
                        if ((diff_s != {WIDTH{1'b0}}) && (n_r > IDX_W'(1))) begin
                            state_r <= S_DECOMP;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end
`else
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= S_DONE;
`endif
                    end
                end
`ifdef FIB_ZECK_EN
                S_DECOMP: begin
                    if (take_s) begin
                        zeck <= zeck | (ZECK_W'(1'b1) << k_next_s);
                    end else begin
                        zeck <= zeck;
                    end
                    res_r <= res_next_s;
                    k_r   <= k_next_s;
                    q_r   <= p_r;
                    p_r   <= q_r - p_r;
                    if (decomp_end_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_DECOMP;
                    end
                end
`endif
                S_DONE: begin
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_index_finder.sv
// Directed bench for fib_index_finder: transaction-level model checked every cycle plus literal expectations.
module tb_fib_index_finder;
    localparam int WIDTH = 5;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] rem;
    logic             exact;
    logic             zero_err;
`ifdef FIB_ZECK_EN
    logic [7:0]       zeck;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fib_index_finder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .value(value),
        .busy(busy),
        .done(done),
        .idx(idx),
        .rem(rem),
        .exact(exact),
        .zero_err(zero_err)
`ifdef FIB_ZECK_EN
        ,
        .zeck(zeck)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fib(input int k);
        int x = 1;
        int y = 1;
        int t;
        for (int i = 1; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return y;
    endfunction

    // Results of the operation the model has accepted but not yet completed
    int p_idx, p_rem, p_exact, p_zero, p_zeck, p_lat;
    // Visible model state
    int m_busy = 0, m_done = 0, m_left = 0;
    int m_idx = 0, m_rem = 0, m_exact = 0, m_zero = 0, m_zeck = 0;

    task automatic model_eval(input int v);
        int n;
`ifdef FIB_ZECK_EN
        int res;
        int k;
`endif
        p_zeck = 0;
        p_lat  = 1;
        if (v == 0) begin
            p_idx = 0; p_rem = 0; p_exact = 0; p_zero = 1;
        end else begin
            n = 1;
            while (fib(n + 1) <= v) n++;
            p_idx   = n;
            p_rem   = v - fib(n);
            p_exact = (p_rem == 0) ? 1 : 0;
            p_zero  = 0;
            p_lat   = n;
            p_zeck  = 1 << n;
`ifdef FIB_ZECK_EN
            res = p_rem;
            k   = n;
            if (res != 0 && k > 1) begin
                do begin
                    p_lat++;
                    if (fib(k - 1) <= res) begin
                        res    = res - fib(k - 1);
                        p_zeck = p_zeck | (1 << (k - 1));
                    end
                    k--;
                end while (res != 0 && k > 1);
            end
`endif
        end
    endtask

    // Transaction model: accept in idle, report after the computed latency, one-cycle done, then idle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_left <= 0;
            m_idx <= 0; m_rem <= 0; m_exact <= 0; m_zero <= 0; m_zeck <= 0;
        end else if (m_done != 0) begin
            m_done <= 0;
        end else if (m_busy != 0) begin
            if (m_left == 1) begin
                m_busy <= 0; m_done <= 1;
                m_idx <= p_idx; m_rem <= p_rem; m_exact <= p_exact;
                m_zero <= p_zero; m_zeck <= p_zeck;
            end
            m_left <= m_left - 1;
        end else if (start) begin
            model_eval(int'(value));
            m_left <= p_lat;
            m_busy <= 1;
        end
    end

    // Cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        if (m_busy == 0) begin
            chk("idx", 32'(idx), 32'(m_idx));
            chk("rem", 32'(rem), 32'(m_rem));
            chk("exact", 32'(exact), 32'(m_exact));
            chk("zero_err", 32'(zero_err), 32'(m_zero));
`ifdef FIB_ZECK_EN
            chk("zeck", 32'(zeck), 32'(m_zeck));
`endif
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] v, output int lat);
        @(negedge clk);
        start = 1'b1;
        value = v;
        lat   = -1;
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = e;
                break;
            end
        end
        if (lat < 0) begin
            errors++;
            checks++;
            $display("FAIL op_timeout: got no done, expected done for value %0d", v);
        end
    endtask

    task automatic chk_res(input string tag, input int e_idx, input int e_rem, input int e_exact,
                           input int e_zero);
        chk({tag, "_idx"}, 32'(idx), 32'(e_idx));
        chk({tag, "_rem"}, 32'(rem), 32'(e_rem));
        chk({tag, "_exact"}, 32'(exact), 32'(e_exact));
        chk({tag, "_zero_err"}, 32'(zero_err), 32'(e_zero));
    endtask

    initial begin
        int lat;
        int n_done;
        bit drained;
        start = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_res("rst", 0, 0, 0, 0);
        rst = 1'b0;

        run_op(5'd0, lat);
        chk("v0_lat", 32'(lat), 32'd1);
        chk_res("v0", 0, 0, 0, 1);

        run_op(5'd1, lat);
        chk("v1_lat", 32'(lat), 32'd1);
        chk_res("v1", 1, 0, 1, 0);
`ifdef FIB_ZECK_EN
        chk("v1_zeck", 32'(zeck), 32'h02);
`endif

        run_op(5'd20, lat);
        chk_res("v20", 6, 7, 0, 0);
`ifdef FIB_ZECK_EN
        chk("v20_zeck", 32'(zeck), 32'h54);
`else
        chk("v20_lat", 32'(lat), 32'd6);
`endif

        run_op(5'd31, lat);
        chk_res("v31", 7, 10, 0, 0);
`ifdef FIB_ZECK_EN
        chk("v31_zeck", 32'(zeck), 32'hA4);
`else
        chk("v31_lat", 32'(lat), 32'd7);
`endif

        run_op(5'd21, lat);
        chk_res("v21", 7, 0, 1, 0);
`ifdef FIB_ZECK_EN
        chk("v21_zeck", 32'(zeck), 32'h80);
`else
        chk("v21_lat", 32'(lat), 32'd7);
`endif

        // Asynchronous reset three cycles into a long search
        @(negedge clk);
        start = 1'b1;
        value = 5'd31;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk_res("mid_rst", 0, 0, 0, 0);
`ifdef FIB_ZECK_EN
        chk("mid_rst_zeck", 32'(zeck), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run_op(5'd5, lat);
        chk_res("after_rst_v5", 4, 0, 1, 0);
`ifdef FIB_ZECK_EN
        chk("after_rst_zeck", 32'(zeck), 32'h10);
`else
        chk("after_rst_lat", 32'(lat), 32'd4);
`endif

        // start held for 10 cycles while value toggles 31/3
        n_done = 0;
        @(negedge clk);
        for (int e = 0; e < 10; e++) begin
            start = 1'b1;
            value = (e % 2 == 0) ? 5'd31 : 5'd3;
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) chk_res("hold_first", 7, 10, 0, 0);
            end
        end
        start = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) chk_res("hold_first", 7, 10, 0, 0);
            end
            if (!busy && !done) begin
                drained = 1'b1;
                break;
            end
        end
        chk("hold_drained", 32'(drained), 32'd1);
`ifdef FIB_ZECK_EN
        chk("hold_ops", 32'(n_done), 32'd1);
`else
        chk("hold_ops", 32'(n_done), 32'd2);
        chk_res("hold_second", 3, 0, 1, 0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

endmodule
